axi_write_response_slave: RTL

Subordinate-side AXI write response (B) channel generator: the counterpart of the write-response receiver on the manager side. It accepts write-completion events from the slave datapath into a small FIFO and presents them one at a time on BID/BRESP/BVALID, holding each response stable until BREADY. It sits between the slave's write-data sink and the AXI interconnect, and provides an occupancy count and state output for debug.

---
 rtl/axi_resp_pkg.sv | 30 +++
 rtl/resp_fifo.sv | 69 ++++++
 rtl/axi_write_response_slave.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/axi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module    : axi_resp_pkg
// Purpose   : Shared definitions for the AXI write-response (B channel)
//             subordinate: response codes, FSM state type and the state
//             encodings reported on the debug output.
// Ports     : none (package)
// Revision  : 1.0 - initial release
// ============================================================================
package axi_resp_pkg;

  // AXI BRESP codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Debug encodings of the response FSM
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_VALID   = 2'b01;
  localparam logic [1:0] ST_STALLED = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_VALID   = ST_VALID,
    S_STALLED = ST_STALLED
  } state_e;

endpackage : axi_resp_pkg
`default_nettype wire

// File: rtl/resp_fifo.sv
`default_nettype none
// ============================================================================
// Module    : resp_fifo
// Purpose   : Synchronous FIFO holding pending write responses. Read data is
//             the current head entry (show-ahead), so the consumer sees the
//             head without an extra cycle.
// Ports     : clk, resetn (async, active-low)
//             push_i / wdata_i  - write tail (ignored when full)
//             pop_i             - drop head (ignored when empty)
//             rdata_o           - head entry
//             count_o           - occupancy 0..DEPTH
//             full_o / empty_o  - occupancy flags
// Revision  : 1.0 - initial release
// ============================================================================
module resp_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
      else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
    end
  end

endmodule : resp_fifo
`default_nettype wire

// File: rtl/axi_write_response_slave.sv
`default_nettype none
// ============================================================================
// Module    : axi_write_response_slave
// Purpose   : Subordinate-side AXI B-channel generator. Write completions are
//             queued in a small FIFO and presented one at a time on
//             BID/BRESP/BVALID, held stable until BREADY.
// Ports     : clk, resetn (async, active-low)
//             cmp_valid/cmp_ready/cmp_id/cmp_resp - completion input
//             BID/BRESP/BVALID/BREADY             - AXI B channel
//             pending           - queued + presented responses
//             timeout           - sticky stall flag
//             current_state_out - IDLE=00, VALID=01, STALLED=10
// Config    : define AXI_WR_RESP_TIMEOUT_EN to build the stall counter; when
//             undefined, timeout is tied low and STALLED is unreachable.
// Revision  : 1.0 - initial release
// ============================================================================
module axi_write_response_slave
  import axi_resp_pkg::*;
#(
  parameter int ID_WIDTH       = 4,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cmp_valid,
  output logic                       cmp_ready,
  input  logic [ID_WIDTH-1:0]        cmp_id,
  input  logic [1:0]                 cmp_resp,
  output logic [ID_WIDTH-1:0]        BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  output logic [$clog2(DEPTH+1):0]   pending,
  output logic                       timeout,
  output logic [1:0]                 current_state_out
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = CW + 1;
  localparam int FW = ID_WIDTH + 2;

  // Invalid configurations (non power-of-two DEPTH, DEPTH<2, zero timeout)
  // select this empty branch; it exists so the parameters are checked in
  // one visible place.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_cfg_invalid
  end

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;
  logic [CW-1:0]       fifo_count;
  logic [FW-1:0]       fifo_rdata;
  logic                fifo_full, fifo_empty;
  logic                bvalid, push, load, stall_hit;

  assign bvalid    = (state_q != S_IDLE);
  // Full means not ready even if the head leaves this cycle: no bypass.
  assign cmp_ready = !fifo_full;
  assign push      = cmp_valid && !fifo_full;
  // Output register refills when empty or its response is being accepted.
  assign load      = (!bvalid || BREADY) && !fifo_empty;

  resp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i ({cmp_id, cmp_resp}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) state_d = S_VALID;
      end
      S_VALID, S_STALLED: begin
        if (BREADY)         state_d = fifo_empty ? S_IDLE : S_VALID;
        else if (stall_hit) state_d = S_STALLED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else if (load) begin
      {bid_q, bresp_q} <= fifo_rdata;
    end
  end

`ifdef AXI_WR_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] stall_cnt_q;
  logic          timeout_q;
  logic          stalling;

  assign stalling  = bvalid && !BREADY;
  // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  assign stall_hit = stalling && (stall_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      if (!stalling)                   stall_cnt_q <= '0;
      else if (stall_cnt_q != TO_LAST) stall_cnt_q <= stall_cnt_q + TO_ONE;
      if (stall_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign BVALID            = bvalid;
  assign BID               = bid_q;
  assign BRESP             = bresp_q;
  assign pending           = {1'b0, fifo_count} + {{(PW-1){1'b0}}, bvalid};
  assign current_state_out = state_q;

endmodule : axi_write_response_slave
`default_nettype wire
